// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, reader state and FIFO entry types for the register-file sweep reader
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } readerState_e;

    typedef struct packed {
        logic                  last;
        logic [REG_ADDR_W-1:0] index;
        logic [DATA_W-1:0]     data;
    } fifoEntry_t;

    // Inclusive range length with wrap from 31 to 0; result is 1..32.
    function automatic logic [REG_ADDR_W:0] sweepLength(
        input logic [REG_ADDR_W-1:0] firstReg,
        input logic [REG_ADDR_W-1:0] lastReg
    );
        logic [REG_ADDR_W-1:0] span;
        span = lastReg - firstReg;
        return {1'b0, span} + (REG_ADDR_W+1)'(1);
    endfunction

endpackage

// File: rtl/regfile_reader_fifo.sv
// rtl/regfile_reader_fifo.sv - synchronous output FIFO with occupancy count and synchronous flush
module regfile_reader_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   flush,
    input  logic                   pushValid,
    input  fifoEntry_t             pushEntry,
    input  logic                   popReady,
    output logic                   headValid,
    output fifoEntry_t             headEntry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

    fifoEntry_t       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign headValid = (count != '0);
    assign headEntry = mem[rdPtr];
    assign doPop     = headValid && popReady;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign doPush    = pushValid && ((count != FULL_COUNT) || doPop);

    always_ff @(posedge clock) begin
        if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - sweeps a register range through a spare read port and streams index-tagged values
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [REG_ADDR_W-1:0] first_reg,
    input  logic [REG_ADDR_W-1:0] last_reg,
    output logic [REG_ADDR_W-1:0] ctrl_readReg,
    input  logic [DATA_W-1:0]     data_readReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    readerState_e          state;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_ADDR_W:0]   remaining;
    logic                  inflight;
    logic                  inflightLast;
    logic [CNT_W-1:0]      fifoCount;
    logic                  flushFifo;
    logic                  pop;
    logic                  issue;
    logic                  drainDone;
    logic                  headValid;
    fifoEntry_t            headEntry;
    fifoEntry_t            pushEntry;

    assign flushFifo = ctrl_reset || (abort && (state != IDLE));
    assign pop       = out_valid && out_ready;
    // Reserve a slot for the read in flight so a stalled consumer can never overflow the FIFO.
    assign issue     = (state == SWEEP) && ((int'(fifoCount) + int'(inflight)) < FIFO_DEPTH);
    assign drainDone = (state == DRAIN) && !inflight &&
                       ((fifoCount == '0) || ((fifoCount == CNT_W'(1)) && pop));

    assign pushEntry = '{last: inflightLast, index: ctrl_readReg, data: data_readReg};

    regfile_reader_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) outFifo (
        .clock    (clock),
        .flush    (flushFifo),
        .pushValid(inflight),
        .pushEntry(pushEntry),
        .popReady (out_ready),
        .headValid(headValid),
        .headEntry(headEntry),
        .count    (fifoCount)
    );

    assign out_valid = headValid;
    assign out_data  = headValid ? headEntry.data  : '0;
    assign out_index = headValid ? headEntry.index : '0;
    assign out_last  = headValid && headEntry.last;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            ctrl_readReg <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
            done         <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            state    <= IDLE;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                ctrl_readReg <= addr;
                addr         <= addr + REG_ADDR_W'(1);
                remaining    <= remaining - (REG_ADDR_W+1)'(1);
                inflightLast <= (remaining == (REG_ADDR_W+1)'(1));
            end
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= SWEEP;
                        addr      <= first_reg;
                        remaining <= sweepLength(first_reg, last_reg);
                    end
                end
                SWEEP: begin
                    if (issue && (remaining == (REG_ADDR_W+1)'(1))) state <= DRAIN;
                end
                DRAIN: begin
                    if (drainDone) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - randomized self-checking bench for regfile_reader against a queue-based sweep model
module tb_regfile_reader;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [37:0] expQ [$];
    int          compared = 0;
    int          mismatched = 0;
    int          doneSeen = 0;
    int          ackCount = 0;
    bit          randomReady = 1'b0;

    regfile_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .start       (start),
        .abort       (abort),
        .first_reg   (first_reg),
        .last_reg    (last_reg),
        .ctrl_readReg(ctrl_readReg),
        .data_readReg(data_readReg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Register file: r0 is hardwired to zero.
    assign data_readReg = (ctrl_readReg == 5'd0) ? 32'd0 : regs[ctrl_readReg];

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        holdPrev;
        logic [37:0] prevPayload;
        if (randomReady) out_ready = 1'($urandom_range(0, 1));
        holdPrev    = out_valid && !out_ready && !abort && !ctrl_reset;
        prevPayload = {out_last, out_index, out_data};
        if (out_valid && out_ready) begin
            ackCount++;
            if (expQ.size() == 0) checkValue("unexpected_entry", 64'(expQ.size()), 64'd1);
            else checkValue("entry", {out_last, out_index, out_data}, expQ.pop_front());
        end
        @(posedge clock);
        #1;
        if (done) doneSeen++;
        if (holdPrev) checkValue("hold_stable", {out_valid, out_last, out_index, out_data}, {1'b1, prevPayload});
    endtask

    task automatic fillExpected(input logic [4:0] f, input logic [4:0] l, output int n);
        logic [4:0] idx;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int k = 0; k < n; k++) begin
            idx = f + 5'(k);
            expQ.push_back({(k == n - 1), idx, (idx == 5'd0) ? 32'd0 : regs[idx]});
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkValue({tag, "_readReg"}, ctrl_readReg, 0);
        checkValue({tag, "_valid"}, out_valid, 0);
        checkValue({tag, "_data"}, out_data, 0);
        checkValue({tag, "_index"}, out_index, 0);
        checkValue({tag, "_last"}, out_last, 0);
        checkValue({tag, "_busy"}, busy, 0);
        checkValue({tag, "_done"}, done, 0);
    endtask

    // midStart >= 0 pulses a second start that many cycles into the sweep; it must be ignored.
    task automatic runSweep(input logic [4:0] f, input logic [4:0] l, input bit rnd, input int midStart);
        int n;
        int lat;
        int firstValid;
        int startDone;
        fillExpected(f, l, n);
        randomReady = rnd;
        if (!rnd) out_ready = 1'b1;
        ackCount  = 0;
        startDone = doneSeen;
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start      = 1'b0;
        lat        = 0;
        firstValid = -1;
        while (!done && lat < 3000) begin
            if (lat == midStart) begin
                start     = 1'b1;
                first_reg = 5'd20;
                last_reg  = 5'd25;
            end
            tick();
            start = 1'b0;
            lat++;
            if (out_valid && firstValid < 0) firstValid = lat;
        end
        checkValue("done_seen", done, 1);
        if (!rnd) begin
            checkValue("first_latency", firstValid, 2);
            checkValue("done_latency", lat, n + 2);
        end
        checkValue("entry_count", ackCount, n);
        checkValue("model_drained", expQ.size(), 0);
        checkValue("busy_after_done", busy, 0);
        randomReady = 1'b0;
        out_ready   = 1'b1;
        tick();
        checkValue("done_pulse_width", done, 0);
        checkValue("done_count", doneSeen - startDone, 1);
        checkValue("idle_valid", out_valid, 0);
        expQ.delete();
    endtask

    initial begin
        int n;
        int guard;
        int startDone;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        regs[3] = 32'h33;
        regs[4] = 32'h44;

        repeat (3) tick();
        checkIdleOutputs("reset");
        ctrl_reset = 1'b0;
        tick();

        runSweep(5'd1, 5'd4, 1'b0, -1);
        runSweep(5'd30, 5'd1, 1'b0, -1);
        runSweep(5'd0, 5'd31, 1'b1, -1);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            runSweep(5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        // Abort after three accepted entries.
        fillExpected(5'd0, 5'd31, n);
        out_ready = 1'b1;
        ackCount  = 0;
        startDone = doneSeen;
        first_reg = 5'd0;
        last_reg  = 5'd31;
        start     = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (ackCount < 3 && guard < 100) begin
            tick();
            guard++;
        end
        checkValue("abort_acks", ackCount, 3);
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        checkValue("abort_valid", out_valid, 0);
        checkValue("abort_busy", busy, 0);
        checkValue("abort_done", done, 0);
        expQ.delete();
        out_ready = 1'b1;
        repeat (5) tick();
        checkValue("abort_no_done", doneSeen - startDone, 0);
        runSweep(5'd0, 5'd0, 1'b0, -1);

        // A start pulse during a sweep must not disturb it.
        runSweep(5'd2, 5'd9, 1'b0, 3);

        // Abort and start together in IDLE: start is dropped.
        abort     = 1'b1;
        start     = 1'b1;
        first_reg = 5'd5;
        last_reg  = 5'd6;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checkValue("abort_start_busy", busy, 0);
        tick();
        checkValue("abort_start_valid", out_valid, 0);

        // Reset mid-sweep with the FIFO backed up.
        fillExpected(5'd0, 5'd31, n);
        startDone = doneSeen;
        out_ready = 1'b0;
        first_reg = 5'd0;
        last_reg  = 5'd31;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        checkValue("stall_valid", out_valid, 1);
        checkValue("stall_busy", busy, 1);
        ctrl_reset = 1'b1;
        tick();
        checkIdleOutputs("midreset");
        ctrl_reset = 1'b0;
        expQ.delete();
        out_ready = 1'b1;
        repeat (4) tick();
        checkValue("midreset_no_done", doneSeen - startDone, 0);
        runSweep(5'd5, 5'd7, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sweep engine that reads a contiguous range of architectural registers through a spare register-file read port. Streams each value, tagged with its register index, out over a valid/ready interface. It is the reading end of the register file, used by the display/debug path to dump processor state without processor involvement. The register file needs no changes: the reader drives a read address and samples the combinational read data.

## Interface
Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, 2..16

Ports:
- clock  in  1  system clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a sweep; ignored while busy
- abort  in  1  single-cycle pulse; cancels the sweep in progress
- first_reg  in  5  first register index; sampled on accepted start
- last_reg  in  5  last register index, inclusive; sampled on accepted start
- ctrl_readReg  out  5  read address to register-file read port (registered)
- data_readReg  in  32  combinational read data for ctrl_readReg
- out_valid  out  1  out_data/out_index/out_last hold a valid entry
- out_ready  in  1  consumer accepts entry when out_valid && out_ready
- out_data  out  32  register value
- out_index  out  5  register index of out_data
- out_last  out  1  entry is final of the sweep
- busy  out  1  sweep in progress (SWEEP or DRAIN)
- done  out  1  one-cycle pulse after the last entry is accepted

## Operation
- Reset values:
  - Outputs: ctrl_readReg=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
  - Internal: FIFO empty, state IDLE.
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE→SWEEP on start. Latches first_reg and last_reg; sets the address counter to first_reg.
  - Sweep length N = ((last_reg − first_reg) mod 32) + 1, range 1..32.
  - last_reg < first_reg wraps 31→0. first_reg == last_reg reads exactly one register.
  - SWEEP issues one address per cycle while (fifo_count + inflight) < FIFO_DEPTH. inflight is 0 or 1.
  - The cycle after an address is issued, data_readReg is pushed with its index. out_last=1 on the N-th entry.
  - SWEEP→DRAIN the cycle the N-th address is issued.
  - DRAIN→IDLE when the FIFO is empty and no read is in flight. done=1 for that one cycle.
- Handshake:
  - out_valid and the payload stay stable until accepted; out_valid never drops without a transfer.
  - A push and a pop in the same cycle on a full FIFO are legal; count is unchanged.
- start while busy: ignored, no side effect.
- abort (any state other than IDLE):
  - Next cycle: FIFO and inflight flushed, out_valid=0, state IDLE, done not pulsed.
  - abort in IDLE: no effect.
  - abort and start in the same cycle: abort wins, start dropped.
- ctrl_reset asserted mid-sweep returns everything to reset values next edge; no done.
- Register 0 reads 0 and is streamed like any other index.
- No atomicity: each register is sampled at its own read cycle. A processor write landing during the sweep may or may not be visible; this is by design.

## Timing
- start sampled at edge 0 → ctrl_readReg=first_reg after edge 1 → data captured at edge 2 → out_valid=1 after edge 2.
- First-entry latency: 2 cycles from start.
- Throughput: 1 entry/cycle with out_ready held high. N registers complete (done) N+2 cycles after start.
- Backpressure: issue stalls within one cycle of the FIFO filling. No entry lost or duplicated.
- ctrl_readReg holds its last value while stalled and in IDLE.

## Structure
- Shared package regfile_pkg:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - Reader state enum {IDLE, SWEEP, DRAIN}.
  - FIFO entry typedef {last, index[4:0], data[31:0]}.
- Sub-module regfile_reader_fifo:
  - Synchronous FIFO, parameterised depth, count output, synchronous flush input.
  - Driven by abort/reset.
- Top level holds the FSM, address counter, remaining-count counter and inflight flag.

## Test plan
- Reset, then start with first_reg=1, last_reg=4, out_ready=1, registers r1..r4=0x11,0x22,0x33,0x44 → entries (1,0x11)..(4,0x44), out_last on index 4, done 6 cycles after start.
- Wrap: first_reg=30, last_reg=1, r0=0 → indices 30,31,0,1 in order with data 0 for index 0; exactly 4 entries.
- Backpressure: full sweep 0..31, out_ready toggled pseudo-randomly, FIFO_DEPTH=4 → 32 entries, no gaps, duplicates or reordering; out_valid never drops without a transfer.
- abort after 3 entries accepted → out_valid=0 next cycle, busy=0, no done. A following start 0..0 yields a single entry with out_last=1.
- start asserted while busy → ignored, entry count unchanged. ctrl_reset mid-sweep → all outputs at reset values the next cycle.
